// File: rtl/ifetch_queue.sv
// Halfword prefetch queue: fetches aligned 4-halfword words, presents one decoded instruction at the head.
// Latency: a filled word is visible at the head one cycle after mem_valid_i; outputs are combinational from the head.
// Backpressure: the head holds while inst_ready_i=0; fetch stalls when fewer than 4 halfwords are free.
module ifetch_queue #(
  parameter int unsigned      PC_W     = 25,
  parameter int unsigned      QUEUE_HW = 8,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter bit               EXT64_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req_o,
  output logic [PC_W-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_valid_i,
  input  logic [63:0]     mem_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [63:0]     instruction_o,
  output logic [2:0]      inst_len_o,
  output logic [PC_W-1:0] PC_o,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i
);

  localparam int IW = $clog2(QUEUE_HW);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0]   FILL_LIMIT = CW'(QUEUE_HW - 4);
  localparam logic [PC_W-3:0] BLK_ONE    = 1;

  logic [15:0]     ring_q [QUEUE_HW];
  logic [IW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PC_W-1:0] pc_q, pc_d;
  // Fetch pointer kept as a word (4-halfword) address; the low bits are always zero on the bus.
  logic [PC_W-3:0] fetch_blk_q, fetch_blk_d;
  logic [1:0]      skip_q, skip_d;
  logic            epoch_q, epoch_d;
  logic            req_epoch_q, req_epoch_d;
  logic            outst_q, outst_d;
  logic            started_q;

  logic [2:0] head_len;
  logic [2:0] fill_n;
  logic       head_vld, grant, pop, fill;

  // Priority-ordered length decode of the first halfword of an instruction.
  function automatic logic [2:0] decode_len(input logic [15:0] h);
    logic top0;
    top0 = (h[15:11] == 5'd0);
    if (top0 && (h[10:5] == 6'b110001 || h[10:5] == 6'b010111)) return 3'd3;
    else if (top0 && (h[10:5] == 6'b110111) && EXT64_EN)        return 3'd4;
    else if (h[10:9] == 2'b11)                                   return 3'd2;
    else if (top0 && h[9] && h[7])                               return 3'd2;
    else                                                         return 3'd1;
  endfunction

  // Head decode and zero-padded instruction assembly, reading across the ring wrap.
  always_comb begin
    head_len      = decode_len(ring_q[head_q]);
    head_vld      = (count_q != '0) && (count_q >= CW'(head_len));
    inst_valid_o  = head_vld;
    inst_len_o    = head_vld ? head_len : 3'd0;
    instruction_o = '0;
    for (int k = 0; k < 4; k++) begin
      if (head_vld && (3'(k) < head_len)) instruction_o[16*k +: 16] = ring_q[head_q + IW'(k)];
    end
  end

  // Fetch request, handshake qualifiers and the bus-visible PC.
  always_comb begin
    mem_req_o  = started_q && !outst_q && (count_q <= FILL_LIMIT);
    mem_addr_o = started_q ? {fetch_blk_q, 2'b00} : '0;
    PC_o       = started_q ? pc_q : '0;
    grant      = mem_req_o && mem_gnt_i;
    pop        = head_vld && inst_ready_i && !redirect_i;
    // Responses from before a redirect carry the old epoch and are thrown away.
    fill       = mem_valid_i && outst_q && (req_epoch_q == epoch_q) && !redirect_i;
    fill_n     = 3'd4 - {1'b0, skip_q};
  end

  // Next-state: redirect flushes and retargets; otherwise pop and fill both apply.
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pc_d        = pc_q;
    fetch_blk_d = fetch_blk_q;
    skip_d      = skip_q;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    outst_d     = outst_q;
    if (grant) begin
      outst_d     = 1'b1;
      req_epoch_d = epoch_q;
    end else if (mem_valid_i && outst_q) begin
      outst_d     = 1'b0;
    end
    if (redirect_i) begin
      head_d      = tail_q;
      count_d     = '0;
      epoch_d     = ~epoch_q;
      pc_d        = redirect_pc_i;
      fetch_blk_d = redirect_pc_i[PC_W-1:2];
      skip_d      = redirect_pc_i[1:0];
    end else begin
      if (grant) fetch_blk_d = fetch_blk_q + BLK_ONE;
      if (pop) begin
        head_d = head_q + IW'(head_len);
        pc_d   = pc_q + PC_W'(head_len);
      end
      if (fill) begin
        tail_d = tail_q + IW'(fill_n);
        skip_d = 2'd0;
      end
      count_d = count_q + (fill ? CW'(fill_n) : '0) - (pop ? CW'(head_len) : '0);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pc_q        <= RESET_PC;
      fetch_blk_q <= RESET_PC[PC_W-1:2];
      skip_q      <= RESET_PC[1:0];
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      outst_q     <= 1'b0;
      started_q   <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pc_q        <= pc_d;
      fetch_blk_q <= fetch_blk_d;
      skip_q      <= skip_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      outst_q     <= outst_d;
      started_q   <= 1'b1;
    end
  end

  // Ring write: drop the low `skip` halfwords of a misaligned first word, pack the rest at the tail.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (fill && (2'(k) >= skip_q)) ring_q[tail_q + IW'(k) - IW'(skip_q)] <= mem_i[16*k +: 16];
    end
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Parametrised successor to the V850 instruction fetcher: a halfword-granular prefetch queue between the 64-bit instruction memory port and decode.
- Issues aligned fetch requests and buffers returned words in a ring of halfwords.
- Decodes instruction length (16/32/48/64 bit) at the queue head and presents one complete, zero-padded instruction per handshake together with its PC.
- Supports branch redirect with flush, misaligned redirect targets, and dropping of stale in-flight responses.

Parameters:
PC_W, 25, PC width in halfword units (PC increments by 1 per halfword).
QUEUE_HW, 8, queue depth in halfwords; power of two, >= 8.
RESET_PC, 0, halfword PC fetched first after reset release.
EXT64_EN, 1, 1 enables 64-bit instruction decode; 0 decodes that class as 32-bit.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
mem_req_o  out  1  fetch request; held with mem_addr_o until mem_gnt_i.
mem_addr_o  out  PC_W  fetch address, 4-halfword aligned (bits [1:0] = 0).
mem_gnt_i  in  1  request accepted this cycle.
mem_valid_i  in  1  read data valid; responses return in order.
mem_i  in  64  read data; halfword k is at bits [16k+15:16k].
inst_valid_o  out  1  complete instruction at head.
inst_ready_i  in  1  decode accepts the head instruction.
instruction_o  out  64  head instruction; halfword 0 at [15:0]; unused upper bits are 0.
inst_len_o  out  3  length in halfwords (1..4).
PC_o  out  PC_W  PC of the head instruction.
redirect_i  in  1  flush and restart fetch.
redirect_pc_i  in  PC_W  new PC (any halfword).

Behaviour:
- Reset (reset=0, asynchronous): mem_req_o=0, mem_addr_o=0, inst_valid_o=0, instruction_o=0, inst_len_o=0, PC_o=0, queue empty, no request outstanding, epoch=0, fetch_pc=RESET_PC, skip=RESET_PC[1:0].
  - First cycle after release: mem_req_o=1 with mem_addr_o={RESET_PC[PC_W-1:2],2'b00}.
  - Reset asserted mid-operation abandons everything; a late mem_valid_i after release is dropped (outstanding flag cleared).
- Request rule:
  - At most one outstanding request, counted from grant to valid.
  - Assert mem_req_o only when none is outstanding and free halfwords >= 4 (no credit reserved).
  - On mem_gnt_i, fetch_pc advances by 4.
- Fill: on mem_valid_i with matching epoch, write the 4 halfwords to the tail, skipping the low `skip` halfwords. Clear skip afterwards.
- Length decode of head halfword h (priority order):
  1. h[15:11]==0 and h[10:5] in {110001, 010111}: 3.
  2. h[15:11]==0, h[10:5]==110111, EXT64_EN=1: 4.
  3. h[10:9]==11: 2.
  4. h[15:11]==0, h[9]=1, h[7]=1: 2.
  5. Otherwise: 1.
- Output timing and handshake:
  - inst_valid_o=1 iff count >= inst_len_o. Outputs are combinational from the queue head.
  - Data written at edge t is visible at t+1.
  - Outputs hold stable while inst_valid_o=1 and inst_ready_i=0.
  - On inst_valid_o and inst_ready_i: pop inst_len_o halfwords; PC_o advances by inst_len_o, mod 2^PC_W.
  - When inst_valid_o=0: instruction_o=0 and inst_len_o=0.
- Simultaneous pop and fill in the same cycle are both performed. count never exceeds QUEUE_HW.
- Wrap-around: head and tail indices wrap modulo QUEUE_HW. Instructions straddling the wrap are reassembled correctly.
- Redirect (highest priority) at edge t:
  - Empty the queue, toggle epoch, set PC_o=redirect_pc_i, fetch_pc={redirect_pc_i[PC_W-1:2],2'b00}, skip=redirect_pc_i[1:0].
  - inst_valid_o=0 at t+1. A handshake in the redirect cycle is ignored.
  - If a request is outstanding, its response is discarded (epoch mismatch) and the new mem_req_o waits for it. Otherwise mem_req_o=1 at t+1.
  - A redirect while mem_req_o is pending without grant replaces mem_addr_o next cycle.
- A partial instruction (count < length) waits for the next fill; it is never emitted early.

Test Plan:
1. Reset release, memory returns 0x0001_0000_0000_0000 at 0x0 (all 16-bit) -> four handshakes, PC_o 0,1,2,3, inst_len_o=1 each; mem_addr_o=0x4 requested next.
2. Head h=0x0620 (MOV imm32, 3 hw) followed by a 32-bit h=0x0EC0 -> inst_len_o=3 with instruction_o[47:0] = the three halfwords and [63:48]=0, then inst_len_o=2 at PC_o=3.
3. 64-bit instruction starting at halfword 2 of word 0x0 -> inst_valid_o=0 until word 0x4 arrives; then instruction_o assembles halfwords 2,3 (word 0) and 0,1 (word 4), inst_len_o=4; with EXT64_EN=0 the same h gives inst_len_o=2.
4. redirect_pc_i=0x103 while a request is outstanding -> stale data dropped, next mem_addr_o=0x100, first output PC_o=0x103 containing halfword 3 only.
5. inst_ready_i=0 for 10 cycles -> outputs stable, mem_req_o deasserts once free space < 4, no overflow; resumes on release.
6. Continuous fetch of mixed lengths past 2*QUEUE_HW halfwords -> correct assembly across the index wrap, PC_o monotonic with no gaps.
